// File: rtl/sne_evt_stream_pkg.sv
// Shared types for the SNE event stream: event payload, engine config and the broadcaster slice limit.
package sne_evt_stream_pkg;

  localparam int unsigned SPIKE_BCAST_MAX_SLICES = 32;
  localparam int unsigned SNE_MAX_ENGINES        = 32;
  localparam int unsigned EVT_OP_W               = 4;
  localparam int unsigned EVT_W                  = 32;

  localparam logic [EVT_OP_W-1:0] EVT_IDLE       = 4'h0;
  localparam logic [EVT_OP_W-1:0] EVT_SPIKE      = 4'h1;
  localparam logic [EVT_OP_W-1:0] EVT_ACCUMULATE = 4'h2;
  localparam logic [EVT_OP_W-1:0] EVT_WIPE       = 4'h3;
  localparam logic [EVT_OP_W-1:0] EVT_UPDATE     = 4'h4;

  typedef struct packed {
    logic [EVT_OP_W-1:0] op;
    logic [7:0]          cid;
    logic [19:0]         nid;
  } sne_evt_t;

  typedef struct packed {
    logic [SNE_MAX_ENGINES-1:0] cfg_error_i;
  } reg2hw_t;

  typedef struct packed {
    reg2hw_t reg2hw;
  } config_engine_t;

endpackage

// File: rtl/evt_spike_broadcaster_if.sv
// SNE event stream: valid/ready handshake carrying one sne_evt_t.
interface evt_spike_broadcaster_if;
  import sne_evt_stream_pkg::*;

  logic     valid;
  logic     ready;
  sne_evt_t evt;

  modport src (output valid, output evt, input ready);
  modport dst (input valid, input evt, output ready);

endinterface

// File: rtl/evt_spike_broadcaster.sv
// Forks one spike-class event to N_SLICES slice streams; retires the input once every masked slice has taken it.
// Optional perf counters are built when SPIKE_BCAST_PERF_CNT_EN is defined.
module evt_spike_broadcaster
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned N_SLICES  = 8,
  parameter int unsigned ENGINE_ID = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  config_engine_t              config_i,
  input  logic [N_SLICES-1:0]         slice_mask_i,
  evt_spike_broadcaster_if.dst        evt_stream_spike_dst,
  evt_spike_broadcaster_if.src        evt_stream_slice_src [N_SLICES],
`ifdef SPIKE_BCAST_PERF_CNT_EN
  output logic [31:0]                 evt_cnt_o,
  output logic [15:0]                 drop_cnt_o,
  output logic [31:0]                 stall_cnt_o,
`endif
  output logic                        busy_o
);

  localparam int unsigned EngIdxW = $clog2(SNE_MAX_ENGINES);

  typedef enum logic {IDLE, BCAST} state_e;

  state_e              state_q, state_d;
  sne_evt_t            evt_q, evt_d;
  logic [N_SLICES-1:0] pend_q, pend_d;
  logic [N_SLICES-1:0] slice_rdy, slice_acc;
  logic                out_of_rst_q;
  logic                in_xfer, retire, drop;

  // Per-engine config is reserved; keep it connected without affecting the datapath.
  logic unused_cfg;
  assign unused_cfg = ^{config_i.reg2hw.cfg_error_i[ENGINE_ID[EngIdxW-1:0]], config_i};

  assign evt_stream_spike_dst.ready = out_of_rst_q & (state_q == IDLE);
  assign in_xfer = evt_stream_spike_dst.valid & evt_stream_spike_dst.ready;
  assign busy_o  = (state_q == BCAST);

  // Fork: each slice sees the held event only while it is still pending.
  for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
    assign evt_stream_slice_src[k].valid = pend_q[k];
    assign evt_stream_slice_src[k].evt   = pend_q[k] ? evt_q : '0;
    assign slice_rdy[k]                  = evt_stream_slice_src[k].ready;
  end

  assign slice_acc = pend_q & slice_rdy;

  always_comb begin
    state_d = state_q;
    evt_d   = evt_q;
    pend_d  = pend_q;
    retire  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          evt_d  = evt_stream_spike_dst.evt;
          pend_d = slice_mask_i;
          if (|slice_mask_i) state_d = BCAST;
          else               drop    = 1'b1;
        end
      end
      BCAST: begin
        pend_d = pend_q & ~slice_acc;
        if (pend_d == '0) begin
          state_d = IDLE;
          retire  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      evt_q        <= '0;
      pend_q       <= '0;
      out_of_rst_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      evt_q        <= evt_d;
      pend_q       <= pend_d;
      out_of_rst_q <= 1'b1;
    end
  end

`ifdef SPIKE_BCAST_PERF_CNT_EN
  logic stall;
  assign stall = (state_q == BCAST) & |(pend_q & ~slice_rdy);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_cnt_o   <= '0;
      drop_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (retire) evt_cnt_o   <= evt_cnt_o + 32'd1;
      if (drop)   drop_cnt_o  <= drop_cnt_o + 16'd1;
      if (stall)  stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = retire ^ drop;
`endif

endmodule

// File: tb/tb_evt_spike_broadcaster.sv
// Scoreboard bench for evt_spike_broadcaster: per-slice expected queues filled at capture, drained by a monitor.
module tb_evt_spike_broadcaster;
  import sne_evt_stream_pkg::*;

  localparam int unsigned NS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_engine_t cfg;
  logic [NS-1:0]  mask;
  logic           busy;
  logic [NS-1:0]  srdy, sv, forced_rdy, rnd_rdy;
  sne_evt_t       se [NS];
  bit             rand_rdy;

  evt_spike_broadcaster_if in_if ();
  evt_spike_broadcaster_if slice_if [NS] ();

  for (genvar g = 0; g < NS; g++) begin : g_tb
    assign slice_if[g].ready = srdy[g];
    assign sv[g]             = slice_if[g].valid;
    assign se[g]             = slice_if[g].evt;
  end

  assign srdy = rand_rdy ? rnd_rdy : forced_rdy;

`ifdef SPIKE_BCAST_PERF_CNT_EN
  logic [31:0] evt_cnt, stall_cnt;
  logic [15:0] drop_cnt;
`endif

  evt_spike_broadcaster #(.N_SLICES(NS), .ENGINE_ID(0)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .config_i             (cfg),
    .slice_mask_i         (mask),
    .evt_stream_spike_dst (in_if),
    .evt_stream_slice_src (slice_if),
`ifdef SPIKE_BCAST_PERF_CNT_EN
    .evt_cnt_o            (evt_cnt),
    .drop_cnt_o           (drop_cnt),
    .stall_cnt_o          (stall_cnt),
`endif
    .busy_o               (busy)
  );

  int          vectors = 0;
  int          fails   = 0;
  int unsigned cyc     = 0;
  int          nz_cnt  = 0;
  int          zero_cnt = 0;
  sne_evt_t    q [NS][$];
  bit          held [NS];
  sne_evt_t    held_evt [NS];

  always @(posedge clk) cyc++;

  // Random slice ready, roughly 7 in 8 asserted, changed just after each edge.
  always @(posedge clk) begin
    #1;
    rnd_rdy = NS'($urandom) | NS'($urandom) | NS'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every slice transfer pops that slice's expected queue; held valids must keep evt stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) held[k] = 1'b0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (held[k]) begin
          check($sformatf("stable_valid%0d", k), 32'(sv[k]), 32'd1);
          check($sformatf("stable_evt%0d", k), 32'(se[k]), 32'(held_evt[k]));
        end
        if (sv[k]) begin
          if (q[k].size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL unexpected_valid slice%0d: got evt %0h expected no valid", k, se[k]);
          end else if (srdy[k]) begin
            check($sformatf("slice%0d_evt", k), 32'(se[k]), 32'(q[k].pop_front()));
          end
        end else if (se[k] != '0) begin
          check($sformatf("idle_evt_zero%0d", k), 32'(se[k]), 32'd0);
        end
        held[k]     = sv[k] && !srdy[k];
        held_evt[k] = se[k];
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the capture edge.
  task automatic send(input sne_evt_t e, input logic [NS-1:0] m, output int unsigned cap_cyc);
    int n = 0;
    bit ok = 1'b1;
    in_if.valid = 1'b1;
    in_if.evt   = e;
    mask        = m;
    forever begin
      @(negedge clk);
      if (in_if.ready) break;
      n++;
      if (n > 1000) begin
        vectors++;
        fails++;
        $display("FAIL input_ready_timeout: got ready=0 expected ready=1 within 1000 cycles");
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    if (ok) begin
      for (int k = 0; k < NS; k++) if (m[k]) q[k].push_back(e);
      if (m != '0) nz_cnt++;
      else         zero_cnt++;
    end
    #1;
    cap_cyc     = cyc;
    in_if.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 1000) begin
        vectors++;
        fails++;
        $display("FAIL drain_timeout: got busy=1 expected busy=0 within 1000 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c, c0;
    sne_evt_t    e, e2;
    logic [15:0] d0;
    cfg         = '0;
    mask        = '0;
    in_if.valid = 1'b0;
    in_if.evt   = '0;
    forced_rdy  = '0;
    rand_rdy    = 1'b0;

    // Reset state
    #1;
    check("rst_ready", 32'(in_if.ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valids", 32'(sv), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_ready_held", 32'(in_if.ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(in_if.ready), 32'd1);
`ifdef SPIKE_BCAST_PERF_CNT_EN
    check("rst_evt_cnt", evt_cnt, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;

    // 1: full mask, all ready, 10 back-to-back events
    forced_rdy = '1;
    c0 = 0;
    for (int i = 0; i < 10; i++) begin
      e = sne_evt_t'($urandom);
      e.op = EVT_SPIKE;
      send(e, 8'hFF, c);
      if (i == 0) begin
        c0 = c;
        @(negedge clk);
        check("t1_valids_1cyc", 32'(sv), 32'hFF);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready_low", 32'(in_if.ready), 32'd0);
      end
    end
    @(negedge clk);
    while (busy) @(negedge clk);
    check("t1_20_cycles", 32'(cyc - c0 + 1), 32'd20);
    @(posedge clk);
    #1;

    // 2: mask 05, slice2 stalls 5 cycles
    forced_rdy = 8'h01;
    e = sne_evt_t'($urandom);
    e.op = EVT_ACCUMULATE;
    send(e, 8'h05, c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_s2_valid", 32'(sv[2]), 32'd1);
      check("t2_s2_evt", 32'(se[2]), 32'(e));
      check("t2_in_ready", 32'(in_if.ready), 32'd0);
    end
    forced_rdy = 8'h05;
    @(negedge clk);
    check("t2_ready_after", 32'(in_if.ready), 32'd1);
    check("t2_busy_after", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // 3: zero mask is consumed and dropped
    forced_rdy = '1;
`ifdef SPIKE_BCAST_PERF_CNT_EN
    d0 = drop_cnt;
`else
    d0 = '0;
`endif
    e = sne_evt_t'($urandom);
    send(e, 8'h00, c);
    @(negedge clk);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_ready", 32'(in_if.ready), 32'd1);
    check("t3_valids", 32'(sv), 32'd0);
`ifdef SPIKE_BCAST_PERF_CNT_EN
    check("t3_drop_cnt", 32'(drop_cnt - d0), 32'd1);
`endif
    @(posedge clk);
    #1;

    // 4: mask change during BCAST is ignored, applies to the next event
    forced_rdy = '0;
    e = sne_evt_t'($urandom);
    e.op = EVT_WIPE;
    send(e, 8'h0F, c);
    mask = 8'hF0;
    @(negedge clk);
    check("t4_valids_held", 32'(sv), 32'h0F);
    idle(2);
    forced_rdy = '1;
    idle(2);
    e2 = sne_evt_t'($urandom);
    e2.op = EVT_UPDATE;
    send(e2, mask, c);
    @(negedge clk);
    check("t4_new_mask", 32'(sv), 32'hF0);
    drain();

    // 5: reset in BCAST discards the held event
    forced_rdy = '0;
    e = sne_evt_t'($urandom);
    send(e, 8'h80, c);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valids_async", 32'(sv), 32'd0);
    check("t5_busy_async", 32'(busy), 32'd0);
    check("t5_ready_async", 32'(in_if.ready), 32'd0);
    for (int k = 0; k < NS; k++) q[k].delete();
    nz_cnt   = 0;
    zero_cnt = 0;
    @(negedge clk);
    #2;
    rst_n      = 1'b1;
    forced_rdy = '1;
    @(negedge clk);
    check("t5_ready_release", 32'(in_if.ready), 32'd1);
    repeat (4) @(negedge clk);
    check("t5_no_stale", 32'(sv), 32'd0);
    @(posedge clk);
    #1;

    // 6: randomized traffic against the scoreboard
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [NS-1:0] m;
      if ($urandom_range(0, 7) == 0) idle(1);
      m = ($urandom_range(0, 15) == 0) ? '0 : NS'($urandom);
      send(sne_evt_t'($urandom), m, c);
    end
    drain();
    idle(2);
    for (int k = 0; k < NS; k++) check($sformatf("t6_q%0d_empty", k), 32'(q[k].size()), 32'd0);
`ifdef SPIKE_BCAST_PERF_CNT_EN
    check("t6_evt_cnt", evt_cnt, 32'(nz_cnt));
    check("t6_drop_cnt", 32'(drop_cnt), 32'(16'(zero_cnt)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
